seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
Programmable controller for the serial bit-pattern detector path. It holds the detection configuration: pattern, length, overlapping/non-overlapping mode and sample window. It sequences a detection run (IDLE -> RUN -> DONE), counts matches and reports completion. It sits between the configuration/host side and the serial input stream `x`, replacing fixed-pattern Moore detectors with one configurable block.

Parameters:
PAT_W, 4, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width
WIN_W, 8, sample-window counter width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
cfg_wr  input  1  load configuration (single-cycle strobe)
cfg_pattern  input  PAT_W  pattern; first-received bit = bit [cfg_len-1], last = bit 0
cfg_len  input  $clog2(PAT_W+1)  active pattern length, valid 1..PAT_W
cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping detection
cfg_window  input  WIN_W  samples per run; 0 = unbounded (until stop)
start  input  1  begin run (strobe)
stop  input  1  end run early (strobe)
x  input  1  serial data bit
x_valid  input  1  x sampled this cycle
y  output  1  Moore detect pulse, registered
busy  output  1  high in RUN
done  output  1  high in DONE
match_count  output  CNT_W  matches in current/last run, saturating
cfg_err  output  1  one-cycle pulse on rejected cfg_wr

Behaviour:
- Reset values:
  - state = IDLE; y, busy, done, cfg_err = 0; match_count = 0.
  - Config = pattern 4'b1011 (zero-extended to PAT_W), len 4 (min(4, PAT_W)), overlap 0, window 0.
  - History and fill cleared.
- cfg_wr:
  - Accepted only in IDLE/DONE with 1 <= cfg_len <= PAT_W. The new config is used from the next cycle.
  - Otherwise the config is unchanged and cfg_err pulses high for exactly 1 cycle after the strobe.
- State IDLE or DONE with start=1 -> RUN next cycle:
  - Clears match_count, sample count, history and fill.
  - done drops and busy rises in the same edge.
  - start while in RUN is ignored.
- RUN: each cycle with x_valid=1:
  - hist <= {hist[PAT_W-2:0], x}.
  - sample_cnt increments.
  - fill increments, saturating at cfg_len.
- Match condition, evaluated on the incoming sample:
  - (fill+1) >= cfg_len, AND
  - the low cfg_len bits of {hist, x} equal the low cfg_len bits of cfg_pattern.
- On a match:
  - y = 1 on the next cycle, for exactly 1 cycle (Moore, 1-cycle latency).
  - match_count increments, saturating at 2^CNT_W-1.
  - Non-overlapping mode: fill <= 0, so no bit of the matched pattern is reused.
  - Overlapping mode: fill stays saturated.
- x_valid=0: nothing changes. In IDLE/DONE, x and x_valid are ignored.
- RUN -> DONE when either:
  - stop=1, or
  - cfg_window != 0 and the accepted sample makes sample_cnt == cfg_window.
  - If a sample arrives in the same cycle as the terminating condition, it is processed first (counted, may match), then the state becomes DONE. Its y pulse coincides with the first DONE cycle.
- DONE: done held high and match_count held stable until start or reset.
- Asynchronous reset mid-run aborts immediately to reset values. No partial state survives.
- sample_cnt is WIN_W wide. With cfg_window=0 it may wrap; wrap has no effect.

Optional Feature:
SEQ_DET_IRQ_EN
- Defined: adds ports `irq` (output, 1) and `irq_ack` (input, 1).
  - irq is sticky: set on the RUN->DONE transition, cleared by irq_ack=1 or by start.
  - If set and ack occur in the same cycle, set wins.
  - Reset value of irq is 0.
- Not defined: both ports are absent; all other behaviour is identical.

Test Plan:
- Default config, start, stream 1,0,1,1,0,1,1 (x_valid=1 each cycle), then stop -> y pulses once, the cycle after the 4th bit; match_count=1; done=1.
- cfg_overlap=1, same stream -> y pulses after bits 4 and 7; match_count=2.
- cfg_window=5, overlap=0, stream 1,0,1,1,1,0,1,1 -> DONE after the 5th sample; match_count=1; bits 6..8 ignored, no further y.
- cfg_wr with cfg_len=0, then cfg_wr during RUN -> cfg_err pulses 1 cycle each time; config unchanged (default pattern still detected).
- Pattern 2'b11, len 2, overlap=1, stream 1,1,1,1 with x_valid toggling 1,0,1,0,... -> 3 matches, y only after valid samples; then assert reset mid-run -> all outputs 0 asynchronously.
- With SEQ_DET_IRQ_EN: run to DONE -> irq=1 and held; irq_ack -> irq=0 next cycle; start -> irq stays 0.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector with run sequencing and match counting.
// Optional SEQ_DET_IRQ_EN adds a sticky completion interrupt (irq/irq_ack).
module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_wr,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  input  logic [WIN_W-1:0]           cfg_window,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       x,
  input  logic                       x_valid,
  output logic                       y,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           match_count,
  output logic                       cfg_err
`ifdef SEQ_DET_IRQ_EN
  ,
  output logic                       irq,
  input  logic                       irq_ack
`endif
);

  localparam int LEN_W = $clog2(PAT_W+1);
  localparam int LEN_RST = (PAT_W < 4) ? PAT_W : 4;
  localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [WIN_W-1:0] win_q;
  logic [PAT_W-2:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic [WIN_W-1:0] scnt_q;

  logic [PAT_W-1:0] shf;
  logic [PAT_W-1:0] mask;
  logic [LEN_W:0]   fill_p1;
  logic [WIN_W-1:0] scnt_nx;
  logic             smp;
  logic             hit;
  logic             match;
  logic             win_hit;
  logic             term;
  logic             go;
  logic             cfg_ok;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign shf     = {hist_q, x};
  assign fill_p1 = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign scnt_nx = scnt_q + WIN_W'(1);
  assign smp     = (state == RUN) && x_valid;
  assign hit     = (((shf ^ pat_q) & mask) == '0)
                && (fill_p1 >= {1'b0, len_q});
  assign match   = smp && hit;
  assign win_hit = smp && (win_q != '0) && (scnt_nx == win_q);
  assign term    = (state == RUN) && (stop || win_hit);
  assign go      = (state != RUN) && start;
  assign cfg_ok  = cfg_wr && (state != RUN)
                && (cfg_len != '0)
                && (cfg_len <= LEN_W'(PAT_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      go:      state_nx = RUN;
      term:    state_nx = DONE;
      default: state_nx = state;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q       <= PAT_RST;
      len_q       <= LEN_W'(LEN_RST);
      ovl_q       <= 1'b0;
      win_q       <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      scnt_q      <= '0;
      match_count <= '0;
      y           <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (cfg_ok) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        win_q <= cfg_window;
      end
      cfg_err <= cfg_wr && !cfg_ok;
      y       <= match;
      if (go) begin
        hist_q      <= '0;
        fill_q      <= '0;
        scnt_q      <= '0;
        match_count <= '0;
      end else if (smp) begin
        hist_q <= shf[PAT_W-2:0];
        scnt_q <= scnt_nx;
        // non-overlap restarts the fill so matched bits are not reused
        if (match && !ovl_q)   fill_q <= '0;
        else if (fill_q < len_q) fill_q <= fill_q + LEN_W'(1);
        if (match && (match_count != '1))
          match_count <= match_count + CNT_W'(1);
      end
    end
  end

`ifdef SEQ_DET_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                irq <= 1'b0;
    else if (term)            irq <= 1'b1;
    else if (irq_ack || start) irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: y pulses are checked against
// expected cycle tags queued by the stimulus.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [3:0] cfg_pattern = 4'b0;
  logic [2:0] cfg_len = 3'd0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_window = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       y, busy, done, cfg_err;
  logic [7:0] match_count;
`ifdef SEQ_DET_IRQ_EN
  logic       irq;
  logic       irq_ack = 1'b0;
`endif

  seq_detect_ctrl #(.PAT_W(4), .CNT_W(8), .WIN_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .cfg_wr(cfg_wr),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_window(cfg_window),
    .start(start),
    .stop(stop),
    .x(x),
    .x_valid(x_valid),
    .y(y),
    .busy(busy),
    .done(done),
    .match_count(match_count),
    .cfg_err(cfg_err)
`ifdef SEQ_DET_IRQ_EN
    ,
    .irq(irq),
    .irq_ack(irq_ack)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int expq[$];

  // monitor: every y pulse must match the next queued cycle tag
  always @(negedge clk) begin
    if (y !== 1'b0) begin
      n_cmp++;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL y_pulse: got y=%b at cycle %0d, want no pulse", y, cyc);
      end else begin
        int e;
        e = expq.pop_front();
        if (e != cyc || y !== 1'b1) begin
          n_bad++;
          $display("FAIL y_pulse: got y=%b at cycle %0d, want 1 at cycle %0d",
                   y, cyc, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic b, input logic v, input logic e);
    x = b;
    x_valid = v;
    if (e && v) expq.push_back(cyc + 1);
    tick();
    x = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic stream(input logic [15:0] bits, input logic [15:0] exps,
                        input int n);
    for (int i = n - 1; i >= 0; i--) samp(bits[i], 1'b1, exps[i]);
  endtask

  task automatic cfg(input logic [3:0] p, input logic [2:0] l,
                     input logic o, input logic [7:0] w);
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    cfg_window = w;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_y", 32'(y), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_count", 32'(match_count), 0);

    // default 1011, non-overlap
    do_start();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_done", 32'(done), 0);
    stream(16'b1011011, 16'b0001000, 7);
    do_stop();
    chk("t1_done_end", 32'(done), 1);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_count", 32'(match_count), 1);

    // overlapping
    cfg(4'b1011, 3'd4, 1'b1, 8'd0);
    chk("t2_cfg_ok", 32'(cfg_err), 0);
    do_start();
    chk("t2_count_clr", 32'(match_count), 0);
    stream(16'b1011011, 16'b0001001, 7);
    do_stop();
    chk("t2_count", 32'(match_count), 2);

    // window of 5: samples after DONE are ignored
    cfg(4'b1011, 3'd4, 1'b0, 8'd5);
    do_start();
    stream(16'b10111, 16'b00010, 5);
    chk("t3_done_at5", 32'(done), 1);
    stream(16'b011, 16'b000, 3);
    chk("t3_count", 32'(match_count), 1);

    // window end on a matching sample: y in first DONE cycle
    cfg(4'b1011, 3'd4, 1'b0, 8'd4);
    do_start();
    stream(16'b1011, 16'b0001, 4);
    chk("t3b_done", 32'(done), 1);
    chk("t3b_y", 32'(y), 1);
    chk("t3b_count", 32'(match_count), 1);

    // rejected cfg writes leave config alone
    cfg(4'b0000, 3'd0, 1'b1, 8'd0);
    chk("t4_err_len0", 32'(cfg_err), 1);
    tick();
    chk("t4_err_len0_end", 32'(cfg_err), 0);
    do_start();
    cfg(4'b0011, 3'd2, 1'b1, 8'd0);
    chk("t4_err_run", 32'(cfg_err), 1);
    tick();
    chk("t4_err_run_end", 32'(cfg_err), 0);
    stream(16'b1011, 16'b0001, 4);
    chk("t4_done", 32'(done), 1);
    chk("t4_count", 32'(match_count), 1);

    // 2-bit pattern 11, overlapping, x_valid toggling
    cfg(4'b0011, 3'd2, 1'b1, 8'd0);
    do_start();
    samp(1'b1, 1'b1, 1'b0);
    samp(1'b1, 1'b0, 1'b0);
    samp(1'b1, 1'b1, 1'b1);
    samp(1'b1, 1'b0, 1'b0);
    samp(1'b1, 1'b1, 1'b1);
    samp(1'b1, 1'b0, 1'b0);
    samp(1'b1, 1'b1, 1'b1);
    tick();
    chk("t5_count", 32'(match_count), 3);
    chk("t5_busy", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_arst_busy", 32'(busy), 0);
    chk("t5_arst_count", 32'(match_count), 0);
    chk("t5_arst_done", 32'(done), 0);
    chk("t5_arst_y", 32'(y), 0);
    tick();
    reset = 1'b0;
    tick();

    // config back to default after reset
    do_start();
    stream(16'b1011011, 16'b0001000, 7);
    do_stop();
    chk("t6_count", 32'(match_count), 1);
    chk("t6_done", 32'(done), 1);

`ifdef SEQ_DET_IRQ_EN
    chk("irq_set", 32'(irq), 1);
    tick();
    chk("irq_held", 32'(irq), 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("irq_ack", 32'(irq), 0);
    do_start();
    chk("irq_start", 32'(irq), 0);
    do_stop();
    chk("irq_reset", 32'(irq), 1);
`endif

    repeat (3) tick();
    chk("queue_empty", 32'(expq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
